// File: rtl/digit_cascade_counter.sv
// Multi-digit up/down counter with configurable radix; carry/borrow ripple through
// all digits within one clock. Registered wrap pulses, synchronous clear and clamped load.
module digit_cascade_counter #(
    parameter int RADIX  = 3,
    parameter int DIGITS = 2,
    parameter int DW     = 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 en,
    input  logic                 up,
    input  logic                 down,
    input  logic                 clr,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    output logic [DIGITS*DW-1:0] cnt,
    output logic                 carry,
    output logic                 borrow,
    output logic                 is_zero,
    output logic                 is_max
);

    localparam logic [DW-1:0] DIG_MAX = DW'(RADIX - 1);

    logic [DIGITS-1:0][DW-1:0] dig_q, dig_d;
    logic                      carry_q, carry_d;
    logic                      borrow_q, borrow_d;

    logic [DIGITS-1:0] dig_max, dig_zero;
    logic [DIGITS-1:0] low_max, low_zero;
    logic              all_max, all_zero;
    logic              step_up, step_dn;
    logic [DW-1:0]     ld_dig;

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            dig_max[i]  = (dig_q[i] == DIG_MAX);
            dig_zero[i] = (dig_q[i] == '0);
        end
        // low_max[i]/low_zero[i]: every digit below i is at max/zero
        low_max[0]  = 1'b1;
        low_zero[0] = 1'b1;
        for (int i = 1; i < DIGITS; i++) begin
            low_max[i]  = low_max[i-1] & dig_max[i-1];
            low_zero[i] = low_zero[i-1] & dig_zero[i-1];
        end
        all_max  = &dig_max;
        all_zero = &dig_zero;
    end

    assign step_up = en & up & ~down;
    assign step_dn = en & down & ~up;

    always_comb begin
        dig_d    = dig_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        ld_dig   = '0;
        if (clr) begin
            dig_d = '0;
        end else if (load) begin
            // Out-of-range load digits clamp so no digit ever exceeds RADIX-1
            for (int i = 0; i < DIGITS; i++) begin
                ld_dig   = load_val[i*DW +: DW];
                dig_d[i] = (ld_dig > DIG_MAX) ? DIG_MAX : ld_dig;
            end
        end else if (step_up) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (low_max[i]) begin
                    dig_d[i] = dig_max[i] ? '0 : dig_q[i] + DW'(1);
                end
            end
            carry_d = all_max;
        end else if (step_dn) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (low_zero[i]) begin
                    dig_d[i] = dig_zero[i] ? DIG_MAX : dig_q[i] - DW'(1);
                end
            end
            borrow_d = all_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            dig_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            dig_q    <= dig_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign cnt     = dig_q;
    assign carry   = carry_q;
    assign borrow  = borrow_q;
    assign is_zero = all_zero;
    assign is_max  = all_max;

endmodule

// File: doc/digit_cascade_counter.md
# digit_cascade_counter

Parametrised multi-digit up/down counter with configurable radix and digit count, the generalised successor of the team's two-digit cascaded units/tens counter. Each digit counts 0..RADIX-1 and ripples carry or borrow to the next digit inside one clock. Adds down-counting, synchronous clear, parallel load, enable gating, and registered wrap pulses. Used wherever the design needs a multi-digit event or time counter with per-digit outputs.

## Interface
- RADIX, 3: modulus of every digit; legal range 2..2^DW.
- DIGITS, 2: number of cascaded digits; legal range 1..8.
- DW, 2: bit width of one digit; must satisfy 2^DW >= RADIX.
- clk  in  1  single clock; all state changes on its rising edge.
- n_rst  in  1  reset; synchronous and active-low; sampled on rising clk edge.
- en  in  1  count enable; gates up/down only, not clr/load.
- up  in  1  increment request.
- down  in  1  decrement request.
- clr  in  1  synchronous clear of all digits.
- load  in  1  parallel load of load_val.
- load_val  in  DIGITS*DW  load value; digit i in bits [i*DW +: DW].
- cnt  out  DIGITS*DW  current count; digit 0 (least significant) in bits [DW-1:0].
- carry  out  1  registered one-cycle pulse after an up-wrap from all-max to all-zero.
- borrow  out  1  registered one-cycle pulse after a down-wrap from all-zero to all-max.
- is_zero  out  1  combinational: every digit == 0.
- is_max  out  1  combinational: every digit == RADIX-1.

## Operation
- Priority per rising edge, highest first: n_rst low, clr, load, count, hold.
- n_rst low: all digits 0, carry 0, borrow 0. Outputs after reset: cnt = 0, is_zero = 1, is_max = 0, carry = 0, borrow = 0.
- clr high: all digits 0; carry and borrow 0 that cycle.
- load high, clr low: digit i takes load_val digit i. Any loaded digit >= RADIX clamps to RADIX-1. carry and borrow 0.
- Count step occurs only when en = 1 and exactly one of up or down is 1. up and down both 1 is a hold. en = 0 is a hold.
- Up step:
  - Digit 0 increments.
  - Digit i (i > 0) increments when all lower digits == RADIX-1.
  - A digit at RADIX-1 that increments becomes 0.
- Down step:
  - Digit 0 decrements.
  - Digit i (i > 0) decrements when all lower digits == 0.
  - A digit at 0 that decrements becomes RADIX-1.
- Full wrap:
  - Up from all-max gives all-zero and carry = 1 in the following cycle.
  - Down from all-zero gives all-max and borrow = 1 in the following cycle.
- carry and borrow are 0 in every cycle not immediately following a wrap step.
- The ripple across all DIGITS is combinational within one cycle; no multi-cycle propagation.
- Digit arithmetic uses DW bits; no digit ever holds a value >= RADIX, including after load.

## Timing
- Latency: inputs sampled at edge k; cnt reflects the result after edge k. is_zero and is_max follow cnt combinationally in the same cycle.
- carry and borrow are asserted for exactly the cycle after the wrapping edge, and are cleared on the next edge unless another wrap occurs.
- Continuous up with RADIX=2, DIGITS=1 wraps every 2 cycles, so carry is high every other cycle.
- Reset is synchronous: n_rst low mid-count has no effect until the next rising edge. That edge then zeroes the state regardless of clr, load, en, up or down.
- Asynchronous n_rst edges between clock edges must not change any output.
- clr or load asserted in the same cycle as a wrap-producing count suppresses the wrap; no carry or borrow follows.

## Test plan
- Reset: hold n_rst = 0 for 2 edges with up = en = 1 -> cnt = 0, is_zero = 1, carry = 0; deassert n_rst low between edges -> no change before the next edge.
- Up sequence, RADIX=3, DIGITS=2: en = up = 1 for 9 edges -> digit pairs (tens,units) go 00,01,02,10,11,12,20,21,22,00; carry = 1 only in the cycle after returning to 00; is_max = 1 while at 22.
- Down sequence, same parameters, starting from 00: 3 down steps -> 22, 21, 20; borrow = 1 only in the cycle after 22 is reached.
- Gating: up = down = 1 with en = 1, then up = 1 with en = 0 -> cnt unchanged in both cases.
- Load/clamp, RADIX=3: load_val digits (3,1) -> cnt digits (2,1). Load of 22 with up = 1 in the same cycle -> cnt = 22 and no carry. Next edge with up = 1 -> 00 and carry pulse.
- Priority: clr = load = up = en = 1 at cnt = 22 -> cnt = 0, carry = 0. Then RADIX=10, DIGITS=3 from 099 with up -> 100, and from 999 with up -> 000 plus carry.
